// File: rtl/debounce_sync.sv
// debounce_sync: conditions one raw asynchronous input into a clean, synchronous
// level. A flop synchronizer feeds a four-state qualification FSM. The FSM drives
// a registered level, one-cycle rise/fall pulses and a counter of accepted rises.
//
// Handshake note: this block has no valid/ready interface. Its outputs are
// levels and pulses. rise/fall are registered, high for one cycle only, and
// are never high together.
module debounce_sync #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int EVT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    output logic             dout,
    output logic             rise,
    output logic             fall,
    output logic             busy,
    output logic [EVT_W-1:0] evt_cnt
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] IDLE_LO = 2'd0;
    localparam logic [1:0] WAIT_HI = 2'd1;
    localparam logic [1:0] IDLE_HI = 2'd2;
    localparam logic [1:0] WAIT_LO = 2'd3;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   dout_q, dout_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic [EVT_W-1:0]       evt_q, evt_d;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Synchronizer chain: din enters at bit 0 and shifts toward the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    // Qualification FSM next-state logic. A new level is accepted only after
    // DEBOUNCE_CYCLES consecutive mismatching samples. Any sample that matches
    // the current level restarts qualification from zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        evt_d   = evt_q;
        case (state_q)
            IDLE_LO: begin
                dout_d = 1'b0;
                cnt_d  = '0;
                if (sync_out) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = IDLE_HI;
                        dout_d  = 1'b1;
                        rise_d  = 1'b1;
                        evt_d   = evt_q + EVT_W'(1);
                    end else begin
                        state_d = WAIT_HI;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            WAIT_HI: begin
                if (!sync_out) begin
                    state_d = IDLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_HI;
                    cnt_d   = '0;
                    dout_d  = 1'b1;
                    rise_d  = 1'b1;
                    evt_d   = evt_q + EVT_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            IDLE_HI: begin
                dout_d = 1'b1;
                cnt_d  = '0;
                if (!sync_out) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = IDLE_LO;
                        dout_d  = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        state_d = WAIT_LO;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            WAIT_LO: begin
                if (sync_out) begin
                    state_d = IDLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_LO;
                    cnt_d   = '0;
                    dout_d  = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE_LO;
                cnt_d   = '0;
                dout_d  = 1'b0;
            end
        endcase
    end

    // FSM, counters and output registers. Reset discards any candidate in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE_LO;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            evt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            evt_q   <= evt_d;
        end
    end

    assign busy    = (state_q == WAIT_HI) || (state_q == WAIT_LO);
    assign dout    = dout_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign evt_cnt = evt_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync. The main instance uses default parameters.
// A second instance uses EVT_W=2 and DEBOUNCE_CYCLES=1 to exercise counter wrap.
module tb_debounce_sync;

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic       dout, rise, fall, busy;
    logic [7:0] evt_cnt;

    logic       din2;
    logic       dout2, rise2, fall2, busy2;
    logic [1:0] evt_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    debounce_sync dut (
        .clk(clk), .rst(rst), .din(din), .dout(dout), .rise(rise),
        .fall(fall), .busy(busy), .evt_cnt(evt_cnt)
    );

    debounce_sync #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .EVT_W(2)) dut2 (
        .clk(clk), .rst(rst), .din(din2), .dout(dout2), .rise(rise2),
        .fall(fall2), .busy(busy2), .evt_cnt(evt_cnt2)
    );

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; din = 1'b0; din2 = 1'b0;
        step(); step();
        checks++;
        if (dout !== 1'b0 || rise !== 1'b0 || fall !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outs got dout=%b rise=%b fall=%b busy=%b exp 0000", dout, rise, fall, busy);
        end
        checks++;
        if (evt_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_evt got %0d exp 0", evt_cnt);
        end
        checks++;
        if (dout2 !== 1'b0 || evt_cnt2 !== 2'd0) begin
            errors++;
            $display("FAIL reset_dut2 got dout=%b evt=%0d exp 0 0", dout2, evt_cnt2);
        end
        rst = 1'b0;
    endtask

    // din high for 3 cycles only: qualification starts but never completes.
    task automatic test_glitch();
        din = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            if (e == 4) din = 1'b0;
            step();
            checks++;
            if (dout !== 1'b0 || rise !== 1'b0) begin
                errors++;
                $display("FAIL glitch_edge%0d got dout=%b rise=%b exp 0 0", e, dout, rise);
            end
            if (e == 3 || e == 5 || e == 6) begin
                checks++;
                if (busy !== (e != 6)) begin
                    errors++;
                    $display("FAIL glitch_busy_edge%0d got %b exp %b", e, busy, (e != 6));
                end
            end
        end
        checks++;
        if (busy !== 1'b0 || evt_cnt !== 8'd0) begin
            errors++;
            $display("FAIL glitch_end got busy=%b evt=%0d exp 0 0", busy, evt_cnt);
        end
    endtask

    // Clean rise: busy after edges 3-5, dout/rise after edge 6.
    task automatic test_rise_latency();
        din = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step();
            checks++;
            if (busy !== (e >= 3 && e <= 5) || rise !== (e == 6) || dout !== (e >= 6)) begin
                errors++;
                $display("FAIL rise_edge%0d got busy=%b rise=%b dout=%b exp %b %b %b",
                         e, busy, rise, dout, (e >= 3 && e <= 5), (e == 6), (e >= 6));
            end
        end
        checks++;
        if (evt_cnt !== 8'd1 || fall !== 1'b0) begin
            errors++;
            $display("FAIL rise_evt got evt=%0d fall=%b exp 1 0", evt_cnt, fall);
        end
    endtask

    // dout=1, din toggles every 2 cycles x10, then held 0: one fall 6 edges later.
    task automatic test_bounce_fall();
        for (int t = 0; t < 10; t++) begin
            din = ~din;
            for (int c = 0; c < 2; c++) begin
                step();
                checks++;
                if (dout !== 1'b1 || fall !== 1'b0) begin
                    errors++;
                    $display("FAIL bounce_t%0d got dout=%b fall=%b exp 1 0", t, dout, fall);
                end
            end
        end
        din = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
            checks++;
            if (fall !== (e == 6) || dout !== (e < 6) || rise !== 1'b0) begin
                errors++;
                $display("FAIL fall_edge%0d got fall=%b dout=%b rise=%b exp %b %b 0",
                         e, fall, dout, rise, (e == 6), (e < 6));
            end
        end
        checks++;
        if (evt_cnt !== 8'd1) begin
            errors++;
            $display("FAIL fall_evt got %0d exp 1", evt_cnt);
        end
    endtask

    // Reset while qualifying a rise, then release with din still high.
    task automatic test_reset_mid();
        din = 1'b1;
        step(); step(); step(); step();
        checks++;
        if (busy !== 1'b1 || dout !== 1'b0) begin
            errors++;
            $display("FAIL mid_pre got busy=%b dout=%b exp 1 0", busy, dout);
        end
        rst = 1'b1;
        step();
        checks++;
        if (dout !== 1'b0 || evt_cnt !== 8'd0 || busy !== 1'b0 || rise !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst got dout=%b evt=%0d busy=%b rise=%b exp 0 0 0 0", dout, evt_cnt, busy, rise);
        end
        step();
        rst = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            step();
            checks++;
            if (rise !== (e == 6) || dout !== (e >= 6)) begin
                errors++;
                $display("FAIL mid_edge%0d got rise=%b dout=%b exp %b %b", e, rise, dout, (e == 6), (e >= 6));
            end
        end
        checks++;
        if (evt_cnt !== 8'd1) begin
            errors++;
            $display("FAIL mid_evt got %0d exp 1", evt_cnt);
        end
    endtask

    // EVT_W=2, DEBOUNCE_CYCLES=1: counter 1,2,3,0,1, dout changes 3 edges after din.
    task automatic test_wrap();
        logic [1:0] exp_evt;
        for (int k = 0; k < 5; k++) begin
            exp_evt = 2'(k + 1);
            din2 = 1'b1;
            for (int e = 1; e <= 3; e++) begin
                step();
                checks++;
                if (dout2 !== (e == 3) || rise2 !== (e == 3)) begin
                    errors++;
                    $display("FAIL wrap_rise_k%0d_e%0d got dout=%b rise=%b exp %b %b", k, e, dout2, rise2, (e == 3), (e == 3));
                end
            end
            checks++;
            if (evt_cnt2 !== exp_evt) begin
                errors++;
                $display("FAIL wrap_evt_k%0d got %0d exp %0d", k, evt_cnt2, exp_evt);
            end
            din2 = 1'b0;
            for (int e = 1; e <= 3; e++) begin
                step();
                checks++;
                if (dout2 !== (e != 3) || fall2 !== (e == 3)) begin
                    errors++;
                    $display("FAIL wrap_fall_k%0d_e%0d got dout=%b fall=%b exp %b %b", k, e, dout2, fall2, (e != 3), (e == 3));
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        din = 1'b0;
        din2 = 1'b0;
        test_reset();
        test_glitch();
        test_rise_latency();
        test_bounce_fall();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
